ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Shares the single-port 4 KB Chip-8 program/data RAM between three masters:
//   - boot ROM/font loader (write-only)
//   - cpu (fetch, F?33/F?55/F?65 bursts)
//   - blitter (sprite row reads, read-only)
//  Sits between those masters and the RAM macro; owns ram_en/ram_wr/ram_addr/ram_in.
//  Adds fixed priority, burst locking, starvation relief for the blitter, and
//  per-master read-data tagging.
// PARAMETERS
//  RD_LAT    1   RAM read latency in cycles (ram_out valid RD_LAT cycles after registered ram_en)
//  MAX_WAIT  8   cycles blt_req may wait ungranted before it outranks an unlocked cpu
// PORTS
//  clk         in   1   system clock; all logic on posedge
//  reset       in   1   synchronous, active-high reset
//  ld_req      in   1   loader write request
//  ld_addr     in   12  loader address
//  ld_wdata    in   8   loader write data
//  ld_gnt      out  1   loader access accepted this cycle
//  cpu_req     in   1   cpu request
//  cpu_lock    in   1   cpu holds ownership across consecutive accesses (burst)
//  cpu_wr      in   1   1 = write, 0 = read
//  cpu_addr    in   12  cpu address
//  cpu_wdata   in   8   cpu write data
//  cpu_gnt     out  1   cpu access accepted this cycle
//  cpu_rvalid  out  1   rdata belongs to cpu this cycle
//  blt_req     in   1   blitter read request
//  blt_lock    in   1   blitter holds ownership (sprite burst)
//  blt_addr    in   12  blitter address
//  blt_gnt     out  1   blitter access accepted this cycle
//  blt_rvalid  out  1   rdata belongs to blitter this cycle
//  rdata       out  8   registered copy of ram_out, shared by all masters
//  ram_en      out  1   RAM enable (registered)
//  ram_wr      out  1   RAM write strobe (registered)
//  ram_addr    out  12  RAM address (registered)
//  ram_in      out  8   RAM write data (registered)
//  ram_out     in   8   RAM read data
// BEHAVIOUR
//  - Reset: all outputs 0; owner = NONE; wait counter = 0; tag pipe cleared.
//  - Handshake: master holds req and its addr/wr/wdata until it samples gnt=1.
//    gnt is combinational from owner state and reqs, at most one gnt high per
//    cycle. req & gnt in cycle N = one access; deassert or present the next
//    access in N+1.
//  - Issue: access granted in N appears on ram_* in N+1. Cycles with no grant
//    drive ram_en=0, ram_wr=0; addr and data hold their last value.
//  - Reads: rdata and <m>_rvalid are asserted in cycle N+2+RD_LAT, a single-cycle
//    pulse. Writes produce no rvalid.
//  - Owner FSM: NONE, LD, CPU, BLT.
//    - In NONE, or when the current owner drops lock, arbitrate this cycle:
//      loader > (blt if starved) > cpu > blt.
//    - The owner with lock=1 keeps ownership. Other masters get no gnt even if
//      the owner's req is low, but the loader always preempts at the next access
//      boundary.
//    - Owner with lock=0 returns to NONE after its granted access.
//  - Starvation: wait counter (4 bits, saturating) increments each cycle
//    blt_req & ~blt_gnt and clears on blt_gnt. At count >= MAX_WAIT the blitter
//    outranks an unlocked cpu. A locked cpu is never broken by the blitter.
//  - Simultaneous requests: all three in one cycle -> ld_gnt only. Equal-tier
//    ties cannot occur.
//  - Back-to-back: the same master may be granted every cycle. Reads may be
//    pipelined, and rvalid order equals grant order.
//  - Reset mid-burst: ownership dropped, in-flight tags discarded, no rvalid
//    after reset. Any ram_en pulse already issued is harmless.
//  - Blitter write request: blt has no wr port, so the arbiter never drives
//    ram_wr for a blt grant.
// STRUCTURE
//  - ram_arb.vh: owner codes OWN_NONE/OWN_LD/OWN_CPU/OWN_BLT (2-bit); WAIT_W=4.
//  - Sub-module rd_tag_pipe: shift register of depth RD_LAT+1 carrying
//    {valid, owner}. Its output decodes cpu_rvalid/blt_rvalid aligned with the
//    rdata register.
//  - Top level: owner FSM, priority/starvation logic, ram_* output registers.
// TESTING
//  1. Reset, then single cpu read of 0x200 (RAM holds 0xA2): cpu_gnt at N,
//     ram_en/ram_addr=0x200 at N+1, cpu_rvalid with rdata=0xA2 at N+3 (RD_LAT=1).
//  2. ld_req, cpu_req, blt_req all high in one cycle: only ld_gnt; cpu then
//     granted next; blt last. Writes from the loader land and are read back
//     correctly.
//  3. cpu_lock burst of 4 reads at 0x300..0x303 with blt_req held: no blt_gnt
//     until the cycle after lock drops. Four cpu_rvalid pulses in order; blitter
//     wait counter saturates and is not acted on.
//  4. cpu unlocked requests every cycle, blt_req held: blt_gnt no later than
//     MAX_WAIT+1 cycles after blt_req rises, then counter reads 0.
//  5. Assert reset two cycles into a blt locked read burst: no blt_rvalid
//     afterwards, all gnts 0, next cpu_req granted in the first cycle after
//     reset.
//  6. cpu write 0x5A to 0x0F0 then immediate cpu read 0x0F0: ram_wr=1 then 0 on
//     consecutive cycles, rdata=0x5A.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared owner codes, widths and read-tag type for the RAM arbiter
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_BLT  = 2'd3
    } owner_t;

    localparam int WAIT_W = 4;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - master request/grant buses and RAM macro pins of the RAM arbiter
interface ram_arbiter_if;

    logic        ld_req;
    logic [11:0] ld_addr;
    logic [7:0]  ld_wdata;
    logic        ld_gnt;

    logic        cpu_req;
    logic        cpu_lock;
    logic        cpu_wr;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;

    logic        blt_req;
    logic        blt_lock;
    logic [11:0] blt_addr;
    logic        blt_gnt;
    logic        blt_rvalid;

    logic [7:0]  rdata;

    logic        ram_en;
    logic        ram_wr;
    logic [11:0] ram_addr;
    logic [7:0]  ram_in;
    logic [7:0]  ram_out;

    modport slave (
        input  ld_req, ld_addr, ld_wdata,
        output ld_gnt,
        input  cpu_req, cpu_lock, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid,
        input  blt_req, blt_lock, blt_addr,
        output blt_gnt, blt_rvalid,
        output rdata,
        output ram_en, ram_wr, ram_addr, ram_in,
        input  ram_out
    );

    modport master (
        output ld_req, ld_addr, ld_wdata,
        input  ld_gnt,
        output cpu_req, cpu_lock, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid,
        output blt_req, blt_lock, blt_addr,
        input  blt_gnt, blt_rvalid,
        input  rdata,
        input  ram_en, ram_wr, ram_addr, ram_in,
        output ram_out
    );

endinterface

// File: rtl/ram_arbiter_rd_tag_pipe.sv
// rtl/ram_arbiter_rd_tag_pipe.sv - carries {valid, owner} of each granted read alongside the RAM latency
module ram_arbiter_rd_tag_pipe
    import ram_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output logic    take_data,
    output logic    cpu_rvalid,
    output logic    blt_rvalid
);

    rd_tag_t pipe [0:RD_LAT];

    // last stage lines up with ram_out, so the decode register lines up with rdata
    assign take_data = pipe[RD_LAT].valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                pipe[i] <= '0;
            end
            cpu_rvalid <= 1'b0;
            blt_rvalid <= 1'b0;
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i <= RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            cpu_rvalid <= pipe[RD_LAT].valid && (pipe[RD_LAT].owner == OWN_CPU);
            blt_rvalid <= pipe[RD_LAT].valid && (pipe[RD_LAT].owner == OWN_BLT);
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port Chip-8 RAM arbiter for loader, cpu and blitter
// Fixed priority with burst locking, blitter starvation relief and tagged read returns.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8
) (
    input logic          clk,
    input logic          reset,
    ram_arbiter_if.slave bus
);

    owner_t            owner;
    owner_t            owner_next;
    owner_t            gnt_owner;
    logic [WAIT_W-1:0] wait_cnt;
    logic              starved;
    logic              cpu_hold;
    logic              blt_hold;
    rd_tag_t           tag_in;
    logic              take_data;

    logic              ram_en;
    logic              ram_wr;
    logic [11:0]       ram_addr;
    logic [7:0]        ram_in;
    logic [7:0]        rdata;

    assign starved  = wait_cnt >= WAIT_W'(MAX_WAIT);
    // an owner keeps the slot while locked, and also for the unlocked access that ends its burst
    assign cpu_hold = (owner == OWN_CPU) && (bus.cpu_lock || bus.cpu_req);
    assign blt_hold = (owner == OWN_BLT) && (bus.blt_lock || bus.blt_req);

    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_next;
        end
    end

    always_comb begin
        owner_next = OWN_NONE;
        case (gnt_owner)
            OWN_LD:  owner_next = OWN_LD;
            OWN_CPU: owner_next = bus.cpu_lock ? OWN_CPU : OWN_NONE;
            OWN_BLT: owner_next = bus.blt_lock ? OWN_BLT : OWN_NONE;
            default: owner_next = (cpu_hold || blt_hold) ? owner : OWN_NONE;
        endcase
    end

    always_comb begin
        gnt_owner = OWN_NONE;
        if (reset) begin
            gnt_owner = OWN_NONE;
        end else if (bus.ld_req) begin
            gnt_owner = OWN_LD;
        end else if (cpu_hold) begin
            gnt_owner = bus.cpu_req ? OWN_CPU : OWN_NONE;
        end else if (blt_hold) begin
            gnt_owner = bus.blt_req ? OWN_BLT : OWN_NONE;
        end else if (starved && bus.blt_req) begin
            gnt_owner = OWN_BLT;
        end else if (bus.cpu_req) begin
            gnt_owner = OWN_CPU;
        end else if (bus.blt_req) begin
            gnt_owner = OWN_BLT;
        end
    end

    assign bus.ld_gnt  = (gnt_owner == OWN_LD);
    assign bus.cpu_gnt = (gnt_owner == OWN_CPU);
    assign bus.blt_gnt = (gnt_owner == OWN_BLT);

    always_comb begin
        tag_in.valid = ((gnt_owner == OWN_CPU) && !bus.cpu_wr) || (gnt_owner == OWN_BLT);
        tag_in.owner = gnt_owner;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            ram_en   <= 1'b0;
            ram_wr   <= 1'b0;
            ram_addr <= '0;
            ram_in   <= '0;
            rdata    <= '0;
        end else begin
            if (gnt_owner == OWN_BLT) begin
                wait_cnt <= '0;
            end else if (bus.blt_req && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            ram_en <= (gnt_owner != OWN_NONE);
            case (gnt_owner)
                OWN_LD: begin
                    ram_wr   <= 1'b1;
                    ram_addr <= bus.ld_addr;
                    ram_in   <= bus.ld_wdata;
                end
                OWN_CPU: begin
                    ram_wr   <= bus.cpu_wr;
                    ram_addr <= bus.cpu_addr;
                    ram_in   <= bus.cpu_wdata;
                end
                OWN_BLT: begin
                    ram_wr   <= 1'b0;
                    ram_addr <= bus.blt_addr;
                end
                default: ram_wr <= 1'b0;
            endcase

            if (take_data) begin
                rdata <= bus.ram_out;
            end
        end
    end

    assign bus.ram_en   = ram_en;
    assign bus.ram_wr   = ram_wr;
    assign bus.ram_addr = ram_addr;
    assign bus.ram_in   = ram_in;
    assign bus.rdata    = rdata;

    ram_arbiter_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk        (clk),
        .reset      (reset),
        .tag_in     (tag_in),
        .take_data  (take_data),
        .cpu_rvalid (bus.cpu_rvalid),
        .blt_rvalid (bus.blt_rvalid)
    );

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed bench for ram_arbiter with a behavioural RAM and read-return scoreboard
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   cyc = 0;
    logic mon_on;
    logic [2:0] gnts;

    logic [7:0] mem [0:4095];
    owner_t     exp_own [0:2047];
    logic [7:0] exp_dat [0:2047];

    ram_arbiter_if bus ();

    ram_arbiter #(
        .RD_LAT   (1),
        .MAX_WAIT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign gnts = {bus.ld_gnt, bus.cpu_gnt, bus.blt_gnt};

    // single-port RAM, one cycle read latency
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_in;
            else            bus.ram_out <= mem[bus.ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(exp_own[cyc] == OWN_CPU));
            check("blt_rvalid", 32'(bus.blt_rvalid), 32'(exp_own[cyc] == OWN_BLT));
            if (exp_own[cyc] != OWN_NONE)
                check("rdata", 32'(bus.rdata), 32'(exp_dat[cyc]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            tick();
            mid();
        end
    endtask

    task automatic idle();
        bus.ld_req   = 1'b0;
        bus.cpu_req  = 1'b0;
        bus.cpu_lock = 1'b0;
        bus.cpu_wr   = 1'b0;
        bus.blt_req  = 1'b0;
        bus.blt_lock = 1'b0;
    endtask

    // read granted in the current cycle returns N+2+RD_LAT = N+3
    task automatic expect_read(input owner_t o, input logic [7:0] d);
        exp_own[cyc+3] = o;
        exp_dat[cyc+3] = d;
    endtask

    initial begin
        mem[12'h200] <= 8'hA2;
        mem[12'h201] <= 8'hB1;
        mem[12'h300] <= 8'h30;
        mem[12'h301] <= 8'h31;
        mem[12'h302] <= 8'h32;
        mem[12'h303] <= 8'h33;
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        mon_on = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            exp_own[i] = OWN_NONE;
            exp_dat[i] = 8'h00;
        end
        reset = 1'b1;
        idle();
        bus.ld_addr = '0; bus.ld_wdata = '0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.blt_addr = '0;

        tick();
        mon_on = 1'b1;
        tick();
        bus.ld_req = 1'b1; bus.cpu_req = 1'b1; bus.blt_req = 1'b1;
        mid();
        check("rst_gnt", 32'(gnts), 'b000);
        check("rst_ram_en", 32'(bus.ram_en), 0);
        check("rst_ram_wr", 32'(bus.ram_wr), 0);
        check("rst_ram_addr", 32'(bus.ram_addr), 0);
        check("rst_rdata", 32'(bus.rdata), 0);

        // single cpu read
        tick(); reset = 1'b0; idle();
        bus.cpu_req = 1'b1; bus.cpu_addr = 12'h200;
        expect_read(OWN_CPU, 8'hA2);
        mid(); check("t1_gnt", 32'(gnts), 'b010);
        tick(); idle();
        mid();
        check("t1_ram_en", 32'(bus.ram_en), 1);
        check("t1_ram_addr", 32'(bus.ram_addr), 'h200);
        check("t1_ram_wr", 32'(bus.ram_wr), 0);
        tick(); mid();
        check("t1_ram_en_off", 32'(bus.ram_en), 0);
        check("t1_addr_hold", 32'(bus.ram_addr), 'h200);
        drain(2);

        // three simultaneous requests
        tick();
        bus.ld_req = 1'b1; bus.ld_addr = 12'h010; bus.ld_wdata = 8'h11;
        bus.cpu_req = 1'b1; bus.cpu_addr = 12'h010;
        bus.blt_req = 1'b1; bus.blt_addr = 12'h200;
        mid(); check("t2_all3", 32'(gnts), 'b100);
        tick(); bus.ld_req = 1'b0;
        expect_read(OWN_CPU, 8'h11);
        mid();
        check("t2_cpu", 32'(gnts), 'b010);
        check("t2_ld_wr", 32'(bus.ram_wr), 1);
        check("t2_ld_addr", 32'(bus.ram_addr), 'h010);
        check("t2_ld_data", 32'(bus.ram_in), 'h11);
        tick(); bus.cpu_req = 1'b0;
        expect_read(OWN_BLT, 8'hA2);
        mid(); check("t2_blt", 32'(gnts), 'b001);
        tick(); idle();
        mid();
        check("t2_blt_wr", 32'(bus.ram_wr), 0);
        check("t2_blt_addr", 32'(bus.ram_addr), 'h200);
        drain(3);

        // locked cpu burst with blitter waiting
        tick();
        bus.cpu_req = 1'b1; bus.cpu_lock = 1'b1; bus.cpu_addr = 12'h300;
        bus.blt_req = 1'b1; bus.blt_addr = 12'h201;
        expect_read(OWN_CPU, 8'h30);
        mid(); check("t3_b0", 32'(gnts), 'b010);
        tick(); bus.cpu_addr = 12'h301;
        expect_read(OWN_CPU, 8'h31);
        mid(); check("t3_b1", 32'(gnts), 'b010);
        for (int i = 0; i < 14; i++) begin
            tick(); bus.cpu_req = 1'b0;
            mid(); check("t3_hold", 32'(gnts), 'b000);
        end
        tick(); bus.cpu_req = 1'b1; bus.cpu_addr = 12'h302;
        expect_read(OWN_CPU, 8'h32);
        mid(); check("t3_b2", 32'(gnts), 'b010);
        tick(); bus.cpu_addr = 12'h303; bus.cpu_lock = 1'b0;
        expect_read(OWN_CPU, 8'h33);
        mid();
        check("t3_b3", 32'(gnts), 'b010);
        check("t3_wait_sat", 32'(dut.wait_cnt), 15);
        tick(); bus.cpu_req = 1'b0;
        expect_read(OWN_BLT, 8'hB1);
        mid(); check("t3_blt", 32'(gnts), 'b001);
        tick(); idle();
        mid(); check("t3_wait_clr", 32'(dut.wait_cnt), 0);
        drain(3);

        // unlocked cpu every cycle, starvation relief for the blitter
        for (int i = 0; i <= 8; i++) begin
            tick();
            bus.cpu_req = 1'b1; bus.cpu_addr = 12'h200;
            bus.blt_req = 1'b1; bus.blt_addr = 12'h201;
            if (i < 8) expect_read(OWN_CPU, 8'hA2);
            else       expect_read(OWN_BLT, 8'hB1);
            mid(); check("t4_arb", 32'(gnts), (i < 8) ? 'b010 : 'b001);
        end
        tick(); bus.blt_req = 1'b0;
        expect_read(OWN_CPU, 8'hA2);
        mid();
        check("t4_cpu_after", 32'(gnts), 'b010);
        check("t4_wait_clr", 32'(dut.wait_cnt), 0);
        tick(); idle();
        mid();
        drain(3);

        // reset in the middle of a locked blitter burst
        tick();
        bus.blt_req = 1'b1; bus.blt_lock = 1'b1; bus.blt_addr = 12'h200;
        mid(); check("t5_b0", 32'(gnts), 'b001);
        tick(); bus.blt_addr = 12'h201;
        mid(); check("t5_b1", 32'(gnts), 'b001);
        tick(); reset = 1'b1;
        mid(); check("t5_rst_gnt", 32'(gnts), 'b000);
        tick(); reset = 1'b0; bus.blt_req = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_addr = 12'h300;
        expect_read(OWN_CPU, 8'h30);
        mid();
        check("t5_cpu", 32'(gnts), 'b010);
        check("t5_ram_en", 32'(bus.ram_en), 0);
        tick(); idle();
        mid();
        drain(4);

        // write then immediate read-back
        tick();
        bus.cpu_req = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 12'h0F0; bus.cpu_wdata = 8'h5A;
        mid(); check("t6_wgnt", 32'(gnts), 'b010);
        tick(); bus.cpu_wr = 1'b0;
        expect_read(OWN_CPU, 8'h5A);
        mid();
        check("t6_rgnt", 32'(gnts), 'b010);
        check("t6_wr1", 32'(bus.ram_wr), 1);
        check("t6_waddr", 32'(bus.ram_addr), 'h0F0);
        check("t6_wdata", 32'(bus.ram_in), 'h5A);
        tick(); idle();
        mid();
        check("t6_wr0", 32'(bus.ram_wr), 0);
        check("t6_ren", 32'(bus.ram_en), 1);
        drain(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
